// File: rtl/vscpu_mem_pkg.sv
// rtl/vscpu_mem_pkg.sv - shared widths, limits and FSM state type for the VSCPU memory responder
package vscpu_mem_pkg;

    localparam int VSCPU_ADDR_W          = 14;
    localparam int VSCPU_DATA_W          = 32;
    localparam int VSCPU_MAX_WAIT_STATES = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOST = 2'd2
    } resp_state_t;

endpackage

// File: rtl/vscpu_sram_sp.sv
// rtl/vscpu_sram_sp.sv - behavioural single-port SRAM, 1-cycle registered read, drop-in for the hard macro
module vscpu_sram_sp #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents and read register are deliberately left unreset, like the macro.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/vscpu_mem_responder.sv
// rtl/vscpu_mem_responder.sv - VSCPU memory responder: wait-state FSM, host/CPU port mux, unmapped masking, protocol error flag
module vscpu_mem_responder
    import vscpu_mem_pkg::*;
#(
    parameter int ADDR_W      = VSCPU_ADDR_W,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_req,
    input  logic                    wrEn,
    input  logic [ADDR_W-1:0]       addr_toRAM,
    input  logic [VSCPU_DATA_W-1:0] data_toRAM,
    output logic [VSCPU_DATA_W-1:0] data_fromRAM,
    output logic                    mem_vld,
    input  logic                    host_sel,
    input  logic                    host_req,
    input  logic                    host_we,
    input  logic [ADDR_W-1:0]       host_addr,
    input  logic [VSCPU_DATA_W-1:0] host_wdata,
    output logic [VSCPU_DATA_W-1:0] host_rdata,
    output logic                    host_ack,
    output logic                    proto_err
);

    // Wait-state requests above the supported maximum clamp to it.
    localparam int WS    = (WAIT_STATES > VSCPU_MAX_WAIT_STATES) ? VSCPU_MAX_WAIT_STATES : WAIT_STATES;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WS > 0) ? $clog2(WS + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'((WS > 0) ? WS - 1 : 0);
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    resp_state_t              state;
    logic [CNT_W-1:0]         cnt;
    logic                     rdy_q;
    logic                     cpu_rd_q;
    logic                     rd_pend_q;
    logic                     unm_q;
    logic                     hrd_q;
    logic                     err_q;
    logic [VSCPU_DATA_W-1:0]  rd_buf_q;
    logic [VSCPU_DATA_W-1:0]  data_q;

    logic                     idle;
    logic                     cpu_acc;
    logic                     host_acc;
    logic                     acc_we;
    logic                     acc_mapped;
    logic [ADDR_W-1:0]        acc_addr;
    logic [VSCPU_DATA_W-1:0]  acc_wdata;
    logic [VSCPU_DATA_W-1:0]  sram_rdata;
    logic [VSCPU_DATA_W-1:0]  fresh;

    // rdy_q keeps mem_vld low until the first edge after reset release.
    assign idle     = rdy_q && (state == IDLE);
    assign mem_vld  = idle && !host_sel;
    assign cpu_acc  = mem_vld && mem_req;
    assign host_acc = idle && host_sel && host_req;

    assign acc_addr   = host_sel ? host_addr  : addr_toRAM;
    assign acc_we     = host_sel ? host_we    : wrEn;
    assign acc_wdata  = host_sel ? host_wdata : data_toRAM;
    assign acc_mapped = {1'b0, acc_addr} < DEPTH_L;

    vscpu_sram_sp #(
        .DEPTH  (DEPTH),
        .ADDR_W (IDX_W),
        .DATA_W (VSCPU_DATA_W)
    ) u_sram (
        .clk    (clk),
        .en     ((cpu_acc || host_acc) && acc_mapped),
        .we     (acc_we),
        .addr   (acc_addr[IDX_W-1:0]),
        .wdata  (acc_wdata),
        .rdata  (sram_rdata)
    );

    assign fresh      = unm_q ? '0 : sram_rdata;
    assign host_ack   = (state == HOST);
    assign host_rdata = (host_ack && hrd_q) ? fresh : '0;
    assign proto_err  = err_q;

    // With no wait states the read result bypasses data_q so it is visible at T+1.
    always_comb begin
        data_fromRAM = data_q;
        if (WS == 0 && cpu_rd_q) begin
            data_fromRAM = fresh;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            rdy_q     <= 1'b0;
            cpu_rd_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            unm_q     <= 1'b0;
            hrd_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_buf_q  <= '0;
            data_q    <= '0;
        end else begin
            rdy_q    <= 1'b1;
            cpu_rd_q <= cpu_acc && !wrEn;
            if (cpu_acc || host_acc) begin
                unm_q <= !acc_mapped;
            end
            if (host_acc) begin
                hrd_q <= !host_we;
            end
            if (mem_req && !mem_vld && !host_sel) begin
                err_q <= 1'b1;
            end
            if (cpu_rd_q) begin
                rd_buf_q <= fresh;
            end
            if (WS == 0 && cpu_rd_q) begin
                data_q <= fresh;
            end

            case (state)
                IDLE: begin
                    if (host_acc) begin
                        state <= HOST;
                    end else if (cpu_acc && WS > 0) begin
                        state     <= WAIT;
                        cnt       <= CNT_LOAD;
                        rd_pend_q <= !wrEn;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        rd_pend_q <= 1'b0;
                        if (rd_pend_q) begin
                            data_q <= cpu_rd_q ? fresh : rd_buf_q;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOST:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vscpu_mem_responder.sv
// tb/tb_vscpu_mem_responder.sv - randomized and directed bench for vscpu_mem_responder (WAIT_STATES 0 and 3 side by side)
module tb_vscpu_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req = 1'b0, wrEn = 1'b0;
    logic [13:0] addr_toRAM = '0;
    logic [31:0] data_toRAM = '0;
    logic        host_sel = 1'b0, host_req = 1'b0, host_we = 1'b0;
    logic [13:0] host_addr = '0;
    logic [31:0] host_wdata = '0;

    logic [1:0][31:0] dfr;
    logic [1:0][31:0] hrd;
    logic [1:0]       vld;
    logic [1:0]       hack;
    logic [1:0]       perr;

    always #5 clk = ~clk;

    vscpu_mem_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .mem_req(mem_req), .wrEn(wrEn), .addr_toRAM(addr_toRAM),
        .data_toRAM(data_toRAM), .data_fromRAM(dfr[0]), .mem_vld(vld[0]), .host_sel(host_sel),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(hrd[0]), .host_ack(hack[0]), .proto_err(perr[0])
    );

    vscpu_mem_responder #(.WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst), .mem_req(mem_req), .wrEn(wrEn), .addr_toRAM(addr_toRAM),
        .data_toRAM(data_toRAM), .data_fromRAM(dfr[1]), .mem_vld(vld[1]), .host_sel(host_sel),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(hrd[1]), .host_ack(hack[1]), .proto_err(perr[1])
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: per responder, a word array plus "busy for n more cycles" bookkeeping.
    int          ws [2] = '{0, 3};
    logic [31:0] mem [2][1024];
    bit          m_ready [2] = '{0, 0};
    int          m_stall [2] = '{0, 0};
    bit          m_hbusy [2] = '{0, 0};
    bit          m_hrd [2] = '{0, 0};
    bit          m_pend_rd [2] = '{0, 0};
    bit          m_err [2] = '{0, 0};
    logic [31:0] m_hdata [2] = '{0, 0};
    logic [31:0] m_data [2] = '{0, 0};
    logic [31:0] m_pend [2] = '{0, 0};

    function automatic logic [31:0] mrd(input int k, input logic [13:0] a);
        return (a < 14'd1024) ? mem[k][a[9:0]] : 32'h0;
    endfunction

    function automatic bit exp_vld(input int k);
        return m_ready[k] && m_stall[k] == 0 && !m_hbusy[k] && !host_sel;
    endfunction

    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_ready[k] = 0; m_stall[k] = 0; m_hbusy[k] = 0; m_hrd[k] = 0;
                m_pend_rd[k] = 0; m_err[k] = 0; m_data[k] = 0;
            end else begin
                logic [31:0] rv;
                if (mem_req && !exp_vld(k) && !host_sel) m_err[k] = 1;
                if (!m_ready[k]) begin
                    m_ready[k] = 1;
                end else if (m_hbusy[k]) begin
                    m_hbusy[k] = 0;
                end else if (m_stall[k] > 0) begin
                    m_stall[k]--;
                    if (m_stall[k] == 0 && m_pend_rd[k]) begin
                        m_data[k] = m_pend[k];
                        m_pend_rd[k] = 0;
                    end
                end else if (host_sel) begin
                    if (host_req) begin
                        m_hbusy[k] = 1;
                        m_hrd[k] = !host_we;
                        m_hdata[k] = mrd(k, host_addr);
                        if (host_we && host_addr < 14'd1024) mem[k][host_addr[9:0]] = host_wdata;
                    end
                end else if (mem_req) begin
                    rv = mrd(k, addr_toRAM);
                    if (wrEn) begin
                        if (addr_toRAM < 14'd1024) mem[k][addr_toRAM[9:0]] = data_toRAM;
                    end else if (ws[k] == 0) begin
                        m_data[k] = rv;
                    end else begin
                        m_pend[k] = rv;
                        m_pend_rd[k] = 1;
                    end
                    m_stall[k] = ws[k];
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                chk($sformatf("d%0d_rst_outputs", k), {vld[k], hack[k], perr[k]}, 32'h0);
                chk($sformatf("d%0d_rst_data", k), dfr[k] | hrd[k], 32'h0);
            end else begin
                chk($sformatf("d%0d_mem_vld", k), vld[k], exp_vld(k));
                chk($sformatf("d%0d_proto_err", k), perr[k], m_err[k]);
                chk($sformatf("d%0d_host_ack", k), hack[k], m_hbusy[k]);
                if (exp_vld(k)) chk($sformatf("d%0d_data_fromRAM", k), dfr[k], m_data[k]);
                if (m_hbusy[k] && m_hrd[k]) chk($sformatf("d%0d_host_rdata", k), hrd[k], m_hdata[k]);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 0; mem_req = 0; host_req = 0; host_sel = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_flags", {vld, hack, perr}, 32'h0);
        chk("reset_data", dfr[0] | dfr[1] | hrd[0] | hrd[1], 32'h0);
        rst = 1;
        @(posedge clk); #1;
        chk("release_mem_vld", vld, 32'h3);
        chk("release_proto_err", perr, 32'h0);
    endtask

    task automatic host_op(input bit we, input logic [13:0] a, input logic [31:0] wd,
                           output logic [31:0] rd, output bit ack_ok);
        mem_req = 0;
        if (!host_sel) begin
            host_sel = 1;
            repeat (6) @(posedge clk);
            #1;
        end
        host_req = 1; host_we = we; host_addr = a; host_wdata = wd;
        @(posedge clk); #1;
        host_req = 0; host_we = 0;
        rd = hrd[1];
        ack_ok = hack[0] && hack[1];
        @(posedge clk); #1;
    endtask

    // One CPU access paced by the slower responder; poke re-requests during its first stall cycle.
    task automatic cpu_op(input bit we, input logic [13:0] a, input logic [31:0] wd, input bit poke,
                          output logic [31:0] rd, output int stalls, output logic v0, output logic [31:0] d0);
        int n;
        host_sel = 0; host_req = 0; mem_req = 0;
        #1;
        n = 0;
        while (!vld[1] && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        chk("cpu_accept_timeout", n >= 30, 0);
        mem_req = 1; wrEn = we; addr_toRAM = a; data_toRAM = wd;
        @(posedge clk); #1;
        v0 = vld[0]; d0 = dfr[0];
        mem_req = poke; wrEn = 0;
        stalls = 0;
        while (!vld[1] && stalls < 30) begin
            @(posedge clk); #1;
            mem_req = 0;
            stalls++;
        end
        chk("cpu_complete_timeout", stalls >= 30, 0);
        mem_req = 0;
        rd = dfr[1];
    endtask

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [13:0] a, input logic [13:0] b);
        return {op, 1'b0, a, b};
    endfunction

    logic [31:0] rdv, d0, ins, va, vb;
    logic        v0;
    bit          ack;
    int          st, pc, steps;

    function automatic logic [13:0] pick_addr();
        case ($urandom_range(0, 3))
            0: return 14'($urandom_range(0, 15));
            1: return 14'($urandom_range(1020, 1027));
            2: return 14'h3FFF - 14'($urandom_range(0, 3));
            default: return 14'($urandom);
        endcase
    endfunction

    initial begin
        do_reset();

        for (int i = 0; i < 1024; i++) host_op(1, 14'(i), $urandom, rdv, ack);
        host_op(1, 14'd5, 32'h0000_00AB, rdv, ack);

        cpu_op(0, 14'd5, 0, 0, rdv, st, v0, d0);
        chk("ws0_read5_vld_t1", v0, 1);
        chk("ws0_read5_data_t1", d0, 32'hAB);
        chk("ws3_read5_data", rdv, 32'hAB);
        chk("ws3_read5_stalls", st, 3);

        cpu_op(1, 14'd7, 32'hDEADBEEF, 0, rdv, st, v0, d0);
        chk("ws3_write7_stalls", st, 3);
        chk("ws0_write_keeps_data", d0, 32'hAB);
        cpu_op(0, 14'd7, 0, 0, rdv, st, v0, d0);
        chk("ws3_read7_data", rdv, 32'hDEADBEEF);
        chk("ws3_read7_stalls", st, 3);
        chk("ws0_read7_data_t1", d0, 32'hDEADBEEF);

        cpu_op(0, 14'h3FFF, 0, 0, rdv, st, v0, d0);
        chk("unmapped_read_ws3", rdv, 32'h0);
        chk("unmapped_read_ws0", d0, 32'h0);
        chk("unmapped_stalls", st, 3);

        cpu_op(0, 14'd5, 0, 1, rdv, st, v0, d0);
        chk("err_stalls_unchanged", st, 3);
        chk("err_read_data", rdv, 32'hAB);
        chk("err_flags", perr, 32'h2);

        do_reset();
        host_sel = 1;
        repeat (6) @(posedge clk);
        #1;
        mem_req = 1; wrEn = 1; addr_toRAM = 14'd5; data_toRAM = 32'h1234;
        repeat (4) @(posedge clk);
        #1;
        chk("host_owned_vld", vld, 32'h0);
        mem_req = 0; wrEn = 0;
        chk("host_owned_no_err", perr, 32'h0);
        host_op(0, 14'd5, 0, rdv, ack);
        chk("host_read5_ack", ack, 1);
        chk("host_read5_data", rdv, 32'hAB);

        host_op(1, 14'd0, enc(3'd0, 14'd100, 14'd101), rdv, ack);
        host_op(1, 14'd1, enc(3'd0, 14'd102, 14'd103), rdv, ack);
        host_op(1, 14'd2, enc(3'd6, 14'd105, 14'd102), rdv, ack);
        host_op(1, 14'd3, enc(3'd6, 14'd104, 14'd106), rdv, ack);
        host_op(1, 14'd100, 32'd0, rdv, ack);
        host_op(1, 14'd101, 32'd7, rdv, ack);
        host_op(1, 14'd102, 32'd5, rdv, ack);
        host_op(1, 14'd103, 32'hFFFF_FFFF, rdv, ack);
        host_op(1, 14'd104, 32'd0, rdv, ack);
        host_op(1, 14'd105, 32'd4, rdv, ack);
        host_op(1, 14'd106, 32'd0, rdv, ack);
        pc = 0;
        steps = 0;
        while (pc != 4 && steps < 100) begin
            cpu_op(0, 14'(pc), 0, 0, ins, st, v0, d0);
            cpu_op(0, ins[27:14], 0, 0, va, st, v0, d0);
            cpu_op(0, ins[13:0], 0, 0, vb, st, v0, d0);
            if (ins[31:29] == 3'd0) begin
                cpu_op(1, ins[27:14], va + vb, 0, rdv, st, v0, d0);
                pc = pc + 1;
            end else begin
                pc = (vb == 0) ? int'(va) : pc + 1;
            end
            steps++;
        end
        chk("prog_halt_pc", pc, 4);
        chk("prog_steps", steps, 19);
        host_op(0, 14'd100, 0, rdv, ack);
        chk("prog_sum", rdv, 32'd35);
        host_op(0, 14'd102, 0, rdv, ack);
        chk("prog_counter", rdv, 32'd0);
        chk("prog_no_err", perr, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 7) == 0) host_sel = ~host_sel;
            mem_req = $urandom_range(0, 1);
            wrEn = $urandom_range(0, 1);
            addr_toRAM = pick_addr();
            data_toRAM = $urandom;
            host_req = $urandom_range(0, 1);
            host_we = $urandom_range(0, 1);
            host_addr = pick_addr();
            host_wdata = $urandom;
        end
        @(posedge clk); #1;
        rst = 1; mem_req = 0; host_req = 0;
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
